// File: rtl/shift_exec_unit_pkg.sv
// Shared ISA definitions for the shift execution unit.
// Op encodings, data width and the stage-1 to stage-2 bundle.
package shift_exec_unit_pkg;

  localparam int XLEN = 16;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } shift_op_e;

  // Partially shifted operand plus what stage 2 still has to do.
  typedef struct packed {
    shift_op_e       op;
    logic [1:0]      cnt_hi;
    logic [XLEN-1:0] data;
  } s1_t;

endpackage

// File: rtl/shift_exec_unit_shift_stage.sv
// shift_stage: one combinational ROL/SLL/ROR/SRL step.
// Ports: i_op, i_amt (0..3 steps of GRAN bits), i_data -> o_data.
module shift_stage
  import shift_exec_unit_pkg::*;
#(
  parameter int GRAN = 1
) (
  input  shift_op_e       i_op,
  input  logic [1:0]      i_amt,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_data
);

  localparam int SW = $clog2(XLEN) + 1;

  logic [SW-1:0] w_sh;
  logic [SW-1:0] w_inv;

  assign w_sh  = SW'(i_amt) * SW'(GRAN);
  // Shifting by the full width yields 0, so a zero
  // amount makes the wrap-around term vanish.
  assign w_inv = SW'(XLEN) - w_sh;

  always_comb begin
    o_data = i_data;
    unique case (i_op)
      OP_ROL: o_data = (i_data << w_sh)
                     | (i_data >> w_inv);
      OP_SLL: o_data = i_data << w_sh;
      OP_ROR: o_data = (i_data >> w_sh)
                     | (i_data << w_inv);
      OP_SRL: o_data = i_data >> w_sh;
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_exec_unit.sv
// shift_exec_unit: two-stage valid/ready shift/rotate pipeline.
// Ports: clk, rst, in_valid/in_ready/in_op/in_data/in_cnt,
//        out_valid/out_ready/out_data.
module shift_exec_unit
  import shift_exec_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_data,
  input  logic [3:0]      in_cnt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data
);

  logic            r_s1_v;
  s1_t             r_s1;
  logic            r_s2_v;
  logic [XLEN-1:0] r_s2_data;

  logic            w_s2_load;
  logic [XLEN-1:0] w_s1_res;
  logic [XLEN-1:0] w_s2_res;
  shift_op_e       w_op;

  assign w_op = shift_op_e'(in_op);

  // Stage 2 may drain and refill in the same cycle.
  assign w_s2_load = !r_s2_v || out_ready;
  assign in_ready  = !r_s1_v || w_s2_load;

  assign out_valid = r_s2_v;
  assign out_data  = r_s2_data;

  shift_stage #(.GRAN(1)) u_st1 (
    .i_op   (w_op),
    .i_amt  (in_cnt[1:0]),
    .i_data (in_data),
    .o_data (w_s1_res)
  );

  shift_stage #(.GRAN(4)) u_st2 (
    .i_op   (r_s1.op),
    .i_amt  (r_s1.cnt_hi),
    .i_data (r_s1.data),
    .o_data (w_s2_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s1   <= '0;
    end else if (in_ready) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1.op     <= w_op;
        r_s1.cnt_hi <= in_cnt[3:2];
        r_s1.data   <= w_s1_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) r_s2_data <= w_s2_res;
    end
  end

endmodule

// File: tb/tb_shift_exec_unit.sv
// Scoreboard bench for shift_exec_unit.
// Directed vectors; monitor pops expected results on output.
module tb_shift_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  localparam logic [1:0] ROL = 2'b00;
  localparam logic [1:0] SLL = 2'b01;
  localparam logic [1:0] ROR = 2'b10;
  localparam logic [1:0] SRL = 2'b11;

  typedef struct {
    logic [15:0] d;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          cyc = 0;
  int          checks = 0;
  int          errs = 0;
  bit          hold_v = 0;
  logic [15:0] hold_d;

  shift_exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v && out_valid) begin
        checks++;
        if (out_data !== hold_d) begin
          errs++;
          $display("FAIL hold_stable: out_data=%h required %h",
                   out_data, hold_d);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errs++;
          $display("FAIL unexpected_out: out_data=%h required none",
                   out_data);
        end else begin
          e = sbq.pop_front();
          if (out_data !== e.d) begin
            errs++;
            $display("FAIL result: out_data=%h required %h",
                     out_data, e.d);
          end
          if (e.lat) begin
            checks++;
            if (cyc + 1 - e.acc != 2) begin
              errs++;
              $display("FAIL latency: got %0d required 2",
                       cyc + 1 - e.acc);
            end
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [1:0] op,
                      input logic [15:0] d,
                      input logic [3:0] c,
                      input logic [15:0] x,
                      input bit lat);
    bit ok = 0;
    in_op    = op;
    in_data  = d;
    in_cnt   = c;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back('{d: x, acc: cyc + 1, lat: lat});
        ok = 1;
      end
    end
    if (!ok) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: in_ready=0 required 1");
    end
    tick();
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_data  = 16'($urandom);
    in_cnt   = 4'($urandom);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_data   = '0;
    in_cnt    = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    tick();

    // Single ops with latency checks
    send(SRL, 16'h8000, 4'd15, 16'h0001, 1);
    repeat (3) tick();
    send(ROL, 16'h8001, 4'd1, 16'h0003, 1);
    send(ROR, 16'h0001, 4'd4, 16'h1000, 1);
    send(SLL, 16'hFFFF, 4'd8, 16'hFF00, 1);
    send(ROL, 16'hA5C3, 4'd0, 16'hA5C3, 1);
    send(SLL, 16'hA5C3, 4'd0, 16'hA5C3, 1);
    send(ROR, 16'hA5C3, 4'd0, 16'hA5C3, 1);
    send(SRL, 16'hA5C3, 4'd0, 16'hA5C3, 1);
    send(ROR, 16'h00F0, 4'd5, 16'h8007, 1);
    send(ROL, 16'h8001, 4'd13, 16'h3000, 1);
    send(SRL, 16'hFFFF, 4'd7, 16'h01FF, 1);
    send(SLL, 16'h1234, 4'd6, 16'h8D00, 1);
    repeat (4) tick();

    // Back-to-back burst
    send(ROL, 16'h1234, 4'd4, 16'h2341, 1);
    send(SRL, 16'h1234, 4'd4, 16'h0123, 1);
    send(ROR, 16'h1234, 4'd8, 16'h3412, 1);
    send(SLL, 16'h0001, 4'd15, 16'h8000, 1);
    repeat (4) tick();

    // Backpressure: two held, third refused
    out_ready = 1'b0;
    send(ROL, 16'hABCD, 4'd4, 16'hBCDA, 0);
    send(SRL, 16'hABCD, 4'd12, 16'h000A, 0);
    fork
      send(ROR, 16'hABCD, 4'd4, 16'hDABC, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_in_ready", {15'd0, in_ready}, 16'd0);
          chk("full_out_valid", {15'd0, out_valid}, 16'd1);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    repeat (5) tick();

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(SLL, 16'h1111, 4'd1, 16'h2222, 0);
    send(SRL, 16'h4444, 4'd2, 16'h1111, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("midrst_out_data", out_data, 16'h0000);
    sbq.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    out_ready = 1'b1;
    repeat (8) tick();
    send(SLL, 16'h0F0F, 4'd3, 16'h7878, 1);

    for (int i = 0; i < 50 && sbq.size() != 0; i++) tick();
    checks++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL drain: pending=%0d required 0", sbq.size());
    end
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/shift_exec_unit.md
SHIFT_EXEC_UNIT -- requirements
Module: shift_exec_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, upstream (decode) offers an operation.
REQ-004 SHALL have port in_ready, output, 1, unit accepts the offered operation this cycle.
REQ-005 SHALL have port in_op, input, 2, 00 ROL, 01 SLL, 10 ROR, 11 SRL.
REQ-006 SHALL have port in_data, input, 16, operand to shift.
REQ-007 SHALL have port in_cnt, input, 4, shift/rotate amount 0..15.
REQ-008 SHALL have port out_valid, output, 1, result available to downstream (memory/writeback) stage.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes result this cycle.
REQ-010 SHALL have port out_data, output, 16, shifted/rotated result.

Function
REQ-011 Transfer on either side SHALL occur only in a cycle with valid and ready both high.
REQ-012 Unit SHALL be a two-stage pipeline: stage 1 applies in_cnt[1:0] (shift by 0..3), stage 2 applies in_cnt[3:2] (shift by 0/4/8/12); op and remaining count travel with the data.
REQ-013 Latency SHALL be exactly 2 cycles from accept to out_valid high, given no backpressure.
REQ-014 Throughput SHALL be one operation per cycle while out_ready is held high.
REQ-015 SLL/SRL SHALL fill vacated bits with 0; ROL/ROR SHALL wrap bits around within 16 bits; no sign extension.
REQ-016 in_cnt = 0 SHALL pass in_data unchanged for all ops.
REQ-017 Stage 2 SHALL load when empty or when out_ready is high in the same cycle (drain-and-refill allowed).
REQ-018 in_ready SHALL equal (stage 1 empty) OR (stage 1 advances this cycle); it may depend combinationally on out_ready.
REQ-019 With out_ready low, at most two operations SHALL be held; the third offer SHALL see in_ready low.
REQ-020 Held out_data SHALL remain stable while out_valid high and out_ready low.
REQ-021 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-022 in_op, in_data, in_cnt SHALL be ignored when in_valid is low.

Reset
REQ-023 rst high SHALL immediately clear both stage valid flags; out_valid = 0, out_data = 0x0000.
REQ-024 in_ready SHALL be high in the first cycle after rst deasserts.
REQ-025 rst asserted mid-operation SHALL discard all in-flight operations; none emerge after reset.

Structure
REQ-026 Op encodings (ROL, SLL, ROR, SRL) and data width 16 SHALL live in the shared ISA package.
REQ-027 One sub-module, shift_stage, SHALL implement one combinational 4-op shift stage parameterised by shift granularity (1 or 4) and SHALL be instantiated twice.
REQ-028 Pipeline valid/data registers and handshake logic SHALL be in shift_exec_unit only.

Verification
REQ-029 SRL 0x8000 by 15 -> out_data 0x0001, out_valid 2 cycles after accept.
REQ-030 ROL 0x8001 by 1 -> 0x0003; ROR 0x0001 by 4 -> 0x1000; SLL 0xFFFF by 8 -> 0xFF00; any op by 0 on 0xA5C3 -> 0xA5C3.
REQ-031 Back-to-back 4 ops with out_ready high -> 4 results on 4 consecutive cycles, in order.
REQ-032 out_ready low, 3 ops offered -> 2 accepted, in_ready low on the third, out_data stable; out_ready high -> drain in order, third accepted.
REQ-033 rst pulse with 2 ops in flight -> out_valid 0 immediately, no stale result afterward, in_ready high next cycle.
